// File: rtl/arb_mux.sv
// Packet-level round-robin arbiter feeding one registered valid/ready output stage.
// A grant is held from the first beat through the last beat of a packet.
module arb_mux #(
  parameter int unsigned PORTS      = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PORTS*DATA_WIDTH-1:0]   s_data,
  input  logic [PORTS-1:0]              s_valid,
  input  logic [PORTS-1:0]              s_last,
  output logic [PORTS-1:0]              s_ready,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic                          m_valid,
  output logic                          m_last,
  input  logic                          m_ready,
  output logic                          grant_valid,
  output logic [$clog2(PORTS)-1:0]      grant_encoded
);

  localparam int unsigned GW = $clog2(PORTS);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                  state;
  logic [GW-1:0]           ptr;
  logic [GW-1:0]           winner;
  logic [GW-1:0]           cand;
  logic                    found;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    sel_valid;
  logic                    sel_last;
  logic                    out_free;
  logic                    take;
  logic [GW-1:0]           ptr_next;

  // Round-robin search starting at ptr, wrapping modulo PORTS
  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      cand = GW'((32'(ptr) + i) % PORTS);
      if (!found && s_valid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Granted-port mux and per-port ready
  always_comb begin
    out_free  = m_ready || !m_valid;
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    s_ready   = '0;
    for (int unsigned p = 0; p < PORTS; p++) begin
      if (grant_encoded == GW'(p)) begin
        sel_data   = s_data[p*DATA_WIDTH +: DATA_WIDTH];
        sel_valid  = s_valid[p];
        sel_last   = s_last[p];
        s_ready[p] = (state == BURST) && out_free;
      end
    end
  end

  assign take     = (state == BURST) && sel_valid && out_free;
  assign ptr_next = (grant_encoded == GW'(PORTS - 1)) ? '0 : grant_encoded + GW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= '0;
      grant_valid   <= 1'b0;
      grant_encoded <= '0;
      m_data        <= '0;
      m_valid       <= 1'b0;
      m_last        <= 1'b0;
    end else begin
      // Output stage: load on transfer, drain when consumed with nothing new
      if (take) begin
        m_data  <= sel_data;
        m_last  <= sel_last;
        m_valid <= 1'b1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (|s_valid) begin
            grant_encoded <= winner;
            grant_valid   <= 1'b1;
            state         <= BURST;
          end
        end
        BURST: begin
          if (take && sel_last) begin
            grant_valid <= 1'b0;
            ptr         <= ptr_next;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux: per-port packet sources, a cycle-level reference
// model checked every cycle, and literal expectations for each scenario.
module tb_arb_mux;

  localparam int P  = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [P*DW-1:0] s_data = '0;
  logic [P-1:0]    s_valid = '0;
  logic [P-1:0]    s_last = '0;
  logic [P-1:0]    s_ready;
  logic [DW-1:0]   m_data;
  logic            m_valid;
  logic            m_last;
  logic            m_ready = 1'b1;
  logic            grant_valid;
  logic [1:0]      grant_encoded;

  always #5 clk = ~clk;

  arb_mux #(.PORTS(P), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .grant_valid(grant_valid), .grant_encoded(grant_encoded)
  );

  int errors = 0;
  int checks = 0;

  logic [DW:0] srcq[P][$];
  bit          hold[P];
  bit          acc[P];
  logic [DW:0] delivered[$];
  int          grants[$];
  bit          prev_gv = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int port, input int pkt, input int beat);
    return 32'hC0DE_0000 | 32'(port * 4096 + pkt * 16 + beat);
  endfunction

  // Sources: present queue head unless held; pop after an observed handshake
  always @(posedge clk) begin
    logic [DW:0] head;
    #2;
    for (int p = 0; p < P; p++) begin
      if (acc[p] && srcq[p].size() > 0) void'(srcq[p].pop_front());
      if (!hold[p] && srcq[p].size() > 0) begin
        head = srcq[p][0];
        s_valid[p] = 1'b1;
        s_data[p*DW +: DW] = head[DW-1:0];
        s_last[p] = head[DW];
      end else begin
        s_valid[p] = 1'b0;
        s_last[p]  = 1'b0;
      end
    end
  end

  // Reference model: arbitration by rotating priority, one-entry output slot
  bit          started = 1'b0;
  bit          mbusy;
  int          mg;
  int          mptr;
  bit          mov;
  logic [DW-1:0] mod;
  bit          mol;
  bit          mtake;

  function automatic int rr_pick(input int from, input logic [P-1:0] req);
    for (int k = 0; k < P; k++) begin
      int c;
      c = (from + k) % P;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    started = 1'b1;
    if (rst) begin
      mbusy = 0; mg = 0; mptr = 0; mov = 0; mod = '0; mol = 0;
    end else begin
      mtake = mbusy && s_valid[mg] && (m_ready || !mov);
      if (mtake) begin
        mod = s_data[mg*DW +: DW];
        mol = s_last[mg];
        mov = 1'b1;
      end else if (mov && m_ready) begin
        mov = 1'b0;
      end
      if (!mbusy) begin
        if (s_valid != '0) begin
          mg = rr_pick(mptr, s_valid);
          mbusy = 1'b1;
        end
      end else if (mtake && s_last[mg]) begin
        mbusy = 1'b0;
        mptr = (mg + 1) % P;
      end
    end
  end

  // Mid-cycle compare against the model plus handshake/grant logging
  always @(negedge clk) begin
    logic [P-1:0] exp_ready;
    for (int p = 0; p < P; p++) acc[p] = s_valid[p] && s_ready[p] && !rst;
    if (started) begin
      exp_ready = (mbusy && (m_ready || !mov)) ? (P'(1) << mg) : '0;
      check("m_valid", m_valid, mov);
      if (mov) begin
        check("m_data", m_data, mod);
        check("m_last", m_last, mol);
      end
      check("grant_valid", grant_valid, mbusy);
      if (mbusy) check("grant_encoded", grant_encoded, mg);
      check("s_ready", s_ready, exp_ready);
    end
    if (m_valid && m_ready && !rst) delivered.push_back({m_last, m_data});
    if (grant_valid && !prev_gv) grants.push_back(int'(grant_encoded));
    prev_gv = grant_valid;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int port, input int pkt, input int n);
    for (int b = 0; b < n; b++) srcq[port].push_back({(b == n - 1), mk(port, pkt, b)});
  endtask

  task automatic flush();
    for (int p = 0; p < P; p++) begin
      srcq[p].delete();
      hold[p] = 1'b0;
    end
  endtask

  task automatic clear_logs();
    delivered.delete();
    grants.delete();
  endtask

  task automatic wait_beats(input int n, input int budget);
    int k;
    k = 0;
    while (delivered.size() < n && k < budget) begin
      cyc(1);
      k++;
    end
    check("beat_timeout", delivered.size() >= n, 1);
  endtask

  task automatic check_grants(input string name, input int exp[$]);
    check({name, "_count"}, grants.size(), exp.size());
    for (int i = 0; i < exp.size() && i < grants.size(); i++) check(name, grants[i], exp[i]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    flush();
    // Reset state
    rst = 1'b1;
    cyc(3);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_last", m_last, 0);
    check("rst_grant_valid", grant_valid, 0);
    check("rst_s_ready", s_ready, 0);
    rst = 1'b0;
    cyc(1);

    // Single requester: port 2, three beats
    clear_logs();
    send(2, 0, 3);
    cyc(1);
    check("single_grant_valid", grant_valid, 1);
    check("single_grant_enc", grant_encoded, 2);
    wait_beats(3, 50);
    for (int i = 0; i < 3 && i < delivered.size(); i++)
      check("single_beat", delivered[i], {(i == 2), mk(2, 0, i)});
    // ptr now 3: port 3 beats port 1, then the wrap makes port 1 next
    send(1, 0, 2);
    send(3, 0, 2);
    wait_beats(7, 50);
    check_grants("wrap_grant", '{2, 3, 1});
    check("wrap_first_of_p3", delivered[3], {1'b0, mk(3, 0, 0)});
    check("wrap_first_of_p1", delivered[5], {1'b0, mk(1, 0, 0)});

    // Round-robin fairness from reset
    rst = 1'b1; flush(); cyc(2); rst = 1'b0;
    clear_logs();
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < P; p++) send(p, k, 2);
    wait_beats(16, 300);
    check_grants("rr_grant", '{0, 1, 2, 3, 0, 1, 2, 3});
    for (int i = 0; i < 16 && i < delivered.size(); i++)
      check("rr_beat", delivered[i], {(i % 2 == 1), mk((i / 2) % P, i / 8, i % 2)});

    // Backpressure mid-packet on port 1
    clear_logs();
    send(1, 0, 4);
    wait_beats(2, 50);
    m_ready = 1'b0;
    cyc(2);
    check("bp_m_valid", m_valid, 1);
    check("bp_s_ready", s_ready, 0);
    check("bp_m_data", m_data, mk(1, 0, 2));
    cyc(2);
    check("bp_m_data_hold", m_data, mk(1, 0, 2));
    m_ready = 1'b1;
    wait_beats(4, 50);
    check("bp_count", delivered.size(), 4);
    for (int i = 0; i < 4 && i < delivered.size(); i++)
      check("bp_beat", delivered[i], {(i == 3), mk(1, 0, i)});

    // Requester stall: port 0 drops valid while port 1 waits
    clear_logs();
    send(0, 0, 4);
    send(1, 0, 1);
    wait_beats(1, 50);
    hold[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check("stall_grant", grant_encoded, 0);
      check("stall_s_ready1", s_ready[1], 0);
    end
    hold[0] = 1'b0;
    wait_beats(5, 50);
    check_grants("stall_grant_order", '{0, 1});
    check("stall_p0_last", delivered[3], {1'b1, mk(0, 0, 3)});
    check("stall_p1", delivered[4], {1'b1, mk(1, 0, 0)});

    // Reset during beat 2 of a 4-beat packet
    clear_logs();
    send(0, 2, 4);
    wait_beats(1, 50);
    rst = 1'b1;
    flush();
    cyc(1);
    rst = 1'b0;
    check("mrst_m_valid", m_valid, 0);
    check("mrst_grant_valid", grant_valid, 0);
    check("mrst_s_ready", s_ready, 0);
    clear_logs();
    send(3, 1, 1);
    send(1, 1, 1);
    wait_beats(2, 50);
    check_grants("mrst_grant", '{1, 3});
    check("mrst_p3", delivered[1], {1'b1, mk(3, 1, 0)});

    cyc(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/arb_mux.md
# arb_mux

Packet-level arbitrated multiplexer: shares one downstream valid/ready stream port between `PORTS` upstream requesters using round-robin arbitration. A grant is held from the first beat to the `last` beat of a packet, so packets are never interleaved. The block sits in front of any single-consumer bus resource (memory port, shared FIFO, CSR bus) and owns both the arbitration state and a one-entry registered output stage.

## Interface
- `PORTS`, 4: number of requesters, 2..16.
- `DATA_WIDTH`, 32: beat width in bits.
- `clk`  in  1  clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_data`  in  PORTS*DATA_WIDTH  requester data; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `s_valid`  in  PORTS  per-requester beat valid; also acts as the request.
- `s_last`  in  PORTS  per-requester end-of-packet marker.
- `s_ready`  out  PORTS  per-requester beat accept; at most one bit high.
- `m_data`  out  DATA_WIDTH  registered output data.
- `m_valid`  out  1  registered output valid.
- `m_last`  out  1  registered output end-of-packet.
- `m_ready`  in  1  downstream accept.
- `grant_valid`  out  1  a packet grant is currently held.
- `grant_encoded`  out  $clog2(PORTS)  index of the granted requester; meaningful only when `grant_valid`=1.

## Operation
- States: IDLE, BURST.
- IDLE: `s_ready`=0. If any `s_valid` bit is set, select a winner by round-robin, register `grant_encoded`=winner, `grant_valid`=1, go to BURST. Otherwise stay in IDLE.
- Round-robin: priority pointer `ptr` (reset 0). Search order is ptr, ptr+1, …, PORTS-1, 0, …, ptr-1, and the first set `s_valid` bit wins. When a packet completes, `ptr` = (granted+1) mod PORTS, wrapping at PORTS-1 → 0.
- BURST:
  - `s_ready[g]` = `m_ready` | ~`m_valid` for g = `grant_encoded`; every other `s_ready` bit is 0.
  - Beat transfer when `s_valid[g]` & `s_ready[g]`: load `m_data`/`m_last` from port g and set `m_valid`=1.
  - When the transferred beat has `s_last[g]`=1: clear `grant_valid`, update `ptr`, return to IDLE in the same edge.
- Output register:
  - If `m_valid` & `m_ready` with no new beat loading, `m_valid`→0.
  - While `m_valid`=1 and `m_ready`=0, `m_data`/`m_last` hold stable.
- Granted requester drops `s_valid` mid-packet: grant is held indefinitely and there is no timeout.
- Non-granted `s_valid` is ignored and never dropped; it is served in a later arbitration.
- Single-beat packet (`s_last`=1 on the first beat) is legal: grant spans exactly one transfer cycle.
- The final beat may still sit in the output register while the block is back in IDLE. The next arbitration may proceed, but `s_ready` rules still gate the next load.

## Timing
- Reset values: `s_ready`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `grant_valid`=0, `grant_encoded`=0, `ptr`=0, state IDLE.
- Reset mid-packet: all of the above applies on the next edge. The partial packet is abandoned and the output register is cleared.
- Request → grant: `s_valid` high in IDLE at edge N gives `grant_valid`=1 after edge N.
- Grant → first beat: first beat can be accepted in cycle N+1; `m_valid`=1 after edge N+1.
- Throughput: with `m_ready`=1 held, one beat per cycle within a packet.
- Packet gap: one IDLE (arbitration) cycle between consecutive packets, which gives a 1-cycle bubble on `m_valid`.
- Backpressure: with `m_valid`=1 and `m_ready`=0, `s_ready[g]`=0 combinationally in that cycle.

## Test plan
- Single requester:
  - Stimulus: port 2 sends 3 beats A,B,C (C with last), `m_ready`=1.
  - Required: `grant_encoded`=2 one cycle after request; `m_data` shows A,B,C on consecutive cycles, `m_last` only on C; `grant_valid` drops after C; `ptr`=3.
- Round-robin fairness:
  - Stimulus: all four ports continuously offer 2-beat packets after reset.
  - Required: grant order 0,1,2,3,0,1; each packet contiguous on `m_data`; never two different ports' beats inside one packet.
- Pointer wrap:
  - Stimulus: after port 3 completes a packet, ports 1 and 3 request.
  - Required: port 1 wins, since the search order is 0,1,2,3.
- Backpressure:
  - Stimulus: `m_ready`=0 for 4 cycles mid-packet from port 1.
  - Required: `m_data` holds stable with `m_valid`=1; `s_ready[1]`=0; no beat lost or duplicated after `m_ready` returns to 1.
- Requester stall:
  - Stimulus: granted port 0 drops `s_valid` for 3 cycles mid-packet while port 1 requests.
  - Required: grant stays on 0; port 1 sees `s_ready`=0 until port 0's last beat completes, then port 1 is granted.
- Reset mid-packet:
  - Stimulus: assert `rst` for one cycle during beat 2 of a 4-beat packet.
  - Required: next cycle `m_valid`=0, `grant_valid`=0, all `s_ready`=0; the subsequent request from port 3 is granted with port 0 as top priority (`ptr`=0).
